// File: rtl/mult_18_arb_pkg.sv
// Shared defaults, request bundle type and width check for the
// mult_18 tile arbiter.
package mult_18_arb_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int A_W_DEF     = 19;
   localparam int B_W_DEF     = 19;
   localparam int P_W_DEF     = 38;

   typedef struct packed {
      logic                 sign;
      logic [A_W_DEF-1:0]   a;
      logic [B_W_DEF-1:0]   b;
   } req_t;

   // The tile product is the full-width result of a*b.
   function automatic bit p_w_ok(
      input int a_w,
      input int b_w,
      input int p_w
   );
      return p_w == a_w + b_w;
   endfunction

endpackage

// File: rtl/mult_18_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr.
// Ports: clk, reset, req[N], advance (grant taken), gnt[N] one-hot, gnt_idx.
module rr_arbiter
   import mult_18_arb_pkg::*;
#(
   parameter int N  = NUM_REQ_DEF,
   parameter int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic [IW-1:0] ptr;
   logic          found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int i = 0; i < N; i++) begin
         int j;
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         if (!found && req[j]) begin
            found   = 1'b1;
            gnt_idx = IW'(j);
         end
      end
      if (found) gnt[gnt_idx] = 1'b1;
   end

   // Pointer moves past the winner only when its grant is taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (advance) begin
         if (int'(gnt_idx) == N - 1) ptr <= '0;
         else                        ptr <= gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/mult_18_arbiter.sv
// Shares one mult_18 tile between NUM_REQ valid/ready requesters.
// Ports: clk, reset, req_* (requester side), mult_18_* (tile side),
// rsp_* (tagged product, valid/ready), busy_cnt (S1 occupancy count).
module mult_18_arbiter
   import mult_18_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int A_W     = A_W_DEF,
   parameter int B_W     = B_W_DEF,
   parameter int P_W     = P_W_DEF,
   parameter int ID_W    = $clog2(NUM_REQ),
   parameter int CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ-1:0]     req_sign,
   input  logic [NUM_REQ*A_W-1:0] req_a,
   input  logic [NUM_REQ*B_W-1:0] req_b,
   output logic                   mult_18_sign,
   output logic [A_W-1:0]         mult_18_a,
   output logic [B_W-1:0]         mult_18_b,
   input  logic [P_W-1:0]         mult_18_out,
   output logic                   rsp_valid,
   output logic [ID_W-1:0]        rsp_id,
   output logic [P_W-1:0]         rsp_data,
   input  logic                   rsp_ready,
   output logic [CNT_W-1:0]       busy_cnt
);

   if (!p_w_ok(A_W, B_W, P_W)) begin : g_p_w_bad
      $error("P_W must equal A_W + B_W");
   end

   logic               s1_valid;
   logic               s1_sign;
   logic [A_W-1:0]     s1_a;
   logic [B_W-1:0]     s1_b;
   logic [ID_W-1:0]    s1_id;

   logic               s2_load;
   logic               s1_load;
   logic               accept;
   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_idx;
   logic [A_W-1:0]     sel_a;
   logic [B_W-1:0]     sel_b;

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (ID_W)
   ) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req_valid),
      .advance (accept),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign s2_load = !rsp_valid || rsp_ready;
   assign s1_load = !s1_valid || s2_load;

   // Grant is only offered when S1 can take it and never in reset.
   assign req_ready = (s1_load && !reset) ? gnt : '0;
   assign accept    = |req_ready;

   assign sel_a = req_a[int'(gnt_idx)*A_W +: A_W];
   assign sel_b = req_b[int'(gnt_idx)*B_W +: B_W];

   // Operand register; an empty S1 holds zeros so the tile sees 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_id    <= '0;
      end else if (s1_load) begin
         s1_valid <= accept;
         s1_sign  <= accept & req_sign[gnt_idx];
         s1_a     <= accept ? sel_a : '0;
         s1_b     <= accept ? sel_b : '0;
         s1_id    <= accept ? gnt_idx : '0;
      end
   end

   assign mult_18_sign = s1_sign;
   assign mult_18_a    = s1_a;
   assign mult_18_b    = s1_b;

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else if (s2_load) begin
         rsp_valid <= s1_valid;
         if (s1_valid) begin
            rsp_id   <= s1_id;
            rsp_data <= mult_18_out;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_cnt <= '0;
      end else if (s1_valid && busy_cnt != '1) begin
         busy_cnt <= busy_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mult_18_arbiter.sv
// Scoreboard bench for mult_18_arbiter with a behavioural tile.
// A control model predicts grants; a monitor pops expected products.
module tb_mult_18_arbiter;
   import mult_18_arb_pkg::*;

   localparam int N   = 4;
   localparam int AW  = 19;
   localparam int BW  = 19;
   localparam int PW  = 38;
   localparam int IDW = 2;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [PW-1:0]  d;
   } rsp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      req_ready4;
   logic [N-1:0]      req_sign;
   logic [N*AW-1:0]   req_a;
   logic [N*BW-1:0]   req_b;
   logic              t_sign, t_sign4;
   logic [AW-1:0]     t_a, t_a4;
   logic [BW-1:0]     t_b, t_b4;
   logic [PW-1:0]     t_out, t_out4;
   logic              rsp_valid, rsp_valid4;
   logic [IDW-1:0]    rsp_id, rsp_id4;
   logic [PW-1:0]     rsp_data, rsp_data4;
   logic              rsp_ready;
   logic [15:0]       busy_cnt;
   logic [3:0]        busy4;

   req_t              rq [N];
   logic [PW-1:0]     ex [N];
   int                n_left [N];
   int                op_k = 1;

   int                n_checks = 0;
   int                n_fail = 0;

   logic [N-1:0]      seen_rdy = '0;
   int                m_ptr = 0;
   bit                m_s1 = 0;
   bit                m_rv = 0;
   int                m_busy = 0;
   int                m_busy4 = 0;
   rsp_t              sb [$];

   always #5 clk = ~clk;

   function automatic logic [PW-1:0] prod(
      input logic          s,
      input logic [AW-1:0] a,
      input logic [BW-1:0] b
   );
      logic [PW-1:0] xa, xb;
      xa = s ? {{BW{a[AW-1]}}, a} : {{BW{1'b0}}, a};
      xb = s ? {{AW{b[BW-1]}}, b} : {{AW{1'b0}}, b};
      return xa * xb;
   endfunction

   assign t_out  = prod(t_sign, t_a, t_b);
   assign t_out4 = prod(t_sign4, t_a4, t_b4);

   always_comb begin
      req_sign = '0;
      req_a    = '0;
      req_b    = '0;
      for (int i = 0; i < N; i++) begin
         req_sign[i]          = rq[i].sign;
         req_a[i*AW +: AW]    = rq[i].a;
         req_b[i*BW +: BW]    = rq[i].b;
      end
   end

   mult_18_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_sign     (req_sign),
      .req_a        (req_a),
      .req_b        (req_b),
      .mult_18_sign (t_sign),
      .mult_18_a    (t_a),
      .mult_18_b    (t_b),
      .mult_18_out  (t_out),
      .rsp_valid    (rsp_valid),
      .rsp_id       (rsp_id),
      .rsp_data     (rsp_data),
      .rsp_ready    (rsp_ready),
      .busy_cnt     (busy_cnt)
   );

   mult_18_arbiter #(.CNT_W(4)) dut4 (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready4),
      .req_sign     (req_sign),
      .req_a        (req_a),
      .req_b        (req_b),
      .mult_18_sign (t_sign4),
      .mult_18_a    (t_a4),
      .mult_18_b    (t_b4),
      .mult_18_out  (t_out4),
      .rsp_valid    (rsp_valid4),
      .rsp_id       (rsp_id4),
      .rsp_data     (rsp_data4),
      .rsp_ready    (rsp_ready),
      .busy_cnt     (busy4)
   );

   task automatic chk(
      input string       nm,
      input logic [63:0] act,
      input logic [63:0] req
   );
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s got=%h required=%h at %0t",
                  nm, act, req, $time);
      end
   endtask

   // Control model: predicts req_ready, rsp_valid and busy counts.
   always @(negedge clk) begin
      logic [N-1:0] exp_rdy;
      bit           s1l, s2l, fnd;
      int           g;
      exp_rdy  = '0;
      s1l      = 0;
      s2l      = 0;
      fnd      = 0;
      g        = 0;
      seen_rdy = req_ready;
      if (!reset) begin
         s2l = !m_rv || rsp_ready;
         s1l = !m_s1 || s2l;
         for (int i = 0; i < N; i++) begin
            int j;
            j = (m_ptr + i) % N;
            if (!fnd && req_valid[j]) begin
               fnd = 1;
               g   = j;
            end
         end
         if (s1l && fnd) exp_rdy[g] = 1'b1;
      end
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("req_ready4", 64'(req_ready4), 64'(exp_rdy));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
      chk("rsp_valid4", 64'(rsp_valid4), 64'(m_rv));
      chk("busy_cnt", 64'(busy_cnt), 64'(m_busy));
      chk("busy4", 64'(busy4), 64'(m_busy4));
      if (reset) begin
         m_s1    = 0;
         m_rv    = 0;
         m_ptr   = 0;
         m_busy  = 0;
         m_busy4 = 0;
         sb.delete();
      end else begin
         if (m_s1) begin
            if (m_busy < 65535) m_busy++;
            if (m_busy4 < 15)   m_busy4++;
         end
         if (s2l) m_rv = m_s1;
         if (s1l) begin
            m_s1 = fnd;
            if (fnd) begin
               sb.push_back({IDW'(g), ex[g]});
               m_ptr = (g + 1) % N;
            end
         end
      end
   end

   // Monitor: every delivered response must match the queue head.
   always @(negedge clk) begin
      if (!reset && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_unexpected got id=%0d data=%h required=none",
                     rsp_id, rsp_data);
         end else begin
            rsp_t e;
            e = sb.pop_front();
            chk("rsp_id", 64'(rsp_id), 64'(e.id));
            chk("rsp_data", 64'(rsp_data), 64'(e.d));
            chk("rsp_id4", 64'(rsp_id4), 64'(e.id));
            chk("rsp_data4", 64'(rsp_data4), 64'(e.d));
         end
      end
   end

   task automatic new_ops(input int i);
      rq[i].sign = op_k[0];
      rq[i].a    = AW'(op_k * 7919 + i * 131 + 1);
      rq[i].b    = BW'(op_k * 104729 + 77);
      ex[i]      = prod(rq[i].sign, rq[i].a, rq[i].b);
      op_k++;
   endtask

   task automatic start(input int i, input int n);
      n_left[i]    = n;
      new_ops(i);
      req_valid[i] = 1'b1;
   endtask

   task automatic set_req(
      input int            i,
      input logic          s,
      input logic [AW-1:0] a,
      input logic [BW-1:0] b,
      input logic [PW-1:0] e
   );
      rq[i].sign   = s;
      rq[i].a      = a;
      rq[i].b      = b;
      ex[i]        = e;
      n_left[i]    = 1;
      req_valid[i] = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (req_valid[i] && seen_rdy[i]) begin
            n_left[i]--;
            if (n_left[i] > 0) new_ops(i);
            else               req_valid[i] = 1'b0;
         end
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((req_valid != '0 || m_s1 || m_rv || sb.size() != 0)
             && k < 300) begin
         step();
         k++;
      end
      if (k >= 300) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout got=%0d pending required=0",
                  sb.size());
      end
   endtask

   logic [AW-1:0] snap_a;
   logic [BW-1:0] snap_b;
   logic          snap_s;
   logic [PW-1:0] snap_d;

   initial begin
      reset     = 1'b1;
      rsp_ready = 1'b1;
      req_valid = '0;
      for (int i = 0; i < N; i++) begin
         rq[i]     = '0;
         ex[i]     = '0;
         n_left[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_tile_sign", 64'(t_sign), 64'd0);
      chk("rst_tile_a", 64'(t_a), 64'd0);
      chk("rst_tile_b", 64'(t_b), 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data), 64'd0);
      step();

      // all four streaming, grant order 0,1,2,3,...
      for (int i = 0; i < N; i++) start(i, 6);
      drain();

      // requester 0 unsigned 3*5
      set_req(0, 1'b0, 19'd3, 19'd5, 38'd15);
      drain();

      // requester 2 signed -2*3
      set_req(2, 1'b1, 19'h7FFFE, 19'd3, 38'h3F_FFFF_FFFA);
      drain();

      // unsigned max * max
      set_req(1, 1'b0, 19'h7FFFF, 19'h7FFFF, 38'h3F_FFF0_0001);
      drain();

      // backpressure for 3 cycles with a full pipeline
      for (int i = 0; i < N; i++) start(i, 4);
      repeat (3) step();
      rsp_ready = 1'b0;
      @(negedge clk);
      snap_s = t_sign;
      snap_a = t_a;
      snap_b = t_b;
      snap_d = rsp_data;
      for (int c = 0; c < 2; c++) begin
         step();
         @(negedge clk);
         chk("stall_sign", 64'(t_sign), 64'(snap_s));
         chk("stall_a", 64'(t_a), 64'(snap_a));
         chk("stall_b", 64'(t_b), 64'(snap_b));
         chk("stall_data", 64'(rsp_data), 64'(snap_d));
      end
      step();
      rsp_ready = 1'b1;
      drain();

      // reset with S1 and S2 both full, ptr left at 3
      rsp_ready = 1'b0;
      start(2, 3);
      step();
      step();
      reset        = 1'b1;
      req_valid[2] = 1'b0;
      n_left[2]    = 0;
      set_req(1, 1'b0, 19'd7, 19'd9, 38'd63);
      set_req(3, 1'b1, 19'h7FFFF, 19'h7FFFF, 38'd1);
      step();
      reset     = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", 64'(rsp_valid), 64'd0);
      chk("post_rst_busy", 64'(busy_cnt), 64'd0);
      chk("post_rst_grant", 64'(req_ready), 64'h2);
      drain();

      // continuous traffic saturates the 4-bit counter
      for (int i = 0; i < N; i++) start(i, 5);
      drain();
      chk("busy4_sat", 64'(busy4), 64'd15);
      step();
      chk("busy4_hold", 64'(busy4), 64'd15);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
